// File: rtl/cmd_pkg.sv
// Shared definitions for the command dispatcher: field widths, opcodes,
// target selects, status codes and FSM state encoding.
package cmd_pkg;

    // Default field widths of a command / readback word
    localparam int DEF_OPC_W  = 5;
    localparam int DEF_SEL_W  = 2;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_STAT_W = 4;
    localparam int DEF_CMD_W  = DEF_OPC_W + DEF_SEL_W + DEF_ADDR_W + DEF_DATA_W + DEF_STAT_W;

    // Field LSB offsets for the default layout (opcode is the MSB field)
    localparam int DEF_STAT_LSB = 0;
    localparam int DEF_DATA_LSB = DEF_STAT_LSB + DEF_STAT_W;
    localparam int DEF_ADDR_LSB = DEF_DATA_LSB + DEF_DATA_W;
    localparam int DEF_SEL_LSB  = DEF_ADDR_LSB + DEF_ADDR_W;
    localparam int DEF_OPC_LSB  = DEF_SEL_LSB + DEF_SEL_W;

    // Opcodes; RAM opcodes are reserved and rejected by this engine
    localparam int OPC_NOOP      = 0;
    localparam int OPC_WRITE_REG = 1;
    localparam int OPC_READ_REG  = 2;
    localparam int OPC_WRITE_RAM = 3;
    localparam int OPC_READ_RAM  = 4;

    // Target selects
    localparam int SEL_INT = 0;
    localparam int SEL_DAC = 1;
    localparam int SEL_ADC = 2;

    // Status codes carried in the low bits of a readback word
    localparam int ST_OK      = 0;
    localparam int ST_TIMEOUT = 1;
    localparam int ST_BAD_SEL = 2;
    localparam int ST_BAD_OPC = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_RESPOND
    } state_e;

    // Error counter increment that sticks at all-ones
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cmd_timeout.sv
// Per-transaction ack timeout counter: cleared on load, advanced on count,
// expire flags the count step that reaches TIMEOUT.
module cmd_timeout #(
    parameter int TIMEOUT = 1023
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // Counter: clear at the start of a transaction, +1 per un-acked cycle
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)      cnt <= '0;
        else if (load)  cnt <= '0;
        else if (count) cnt <= cnt + 1'b1;
    end

    assign expire = count && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cmd_dispatcher.sv
// Command engine: pops command words, decodes them, runs one req/ack register
// transaction on the selected target and reports reads/errors to the readback FIFO.
module cmd_dispatcher
    import cmd_pkg::*;
#(
    parameter int OPC_W   = DEF_OPC_W,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int STAT_W  = DEF_STAT_W,
    parameter int CMD_W   = OPC_W + SEL_W + ADDR_W + DATA_W + STAT_W,
    parameter int NUM_TGT = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic [CMD_W-1:0]          cmd_data,
    input  logic                      cmd_empty,
    output logic                      cmd_rd,
    output logic [CMD_W-1:0]          rb_data,
    input  logic                      rb_full,
    output logic                      rb_wr,
    output logic [NUM_TGT-1:0]        tgt_req,
    output logic                      tgt_we,
    output logic [ADDR_W-1:0]         tgt_addr,
    output logic [DATA_W-1:0]         tgt_wdata,
    input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata,
    input  logic [NUM_TGT-1:0]        tgt_ack,
    output logic                      busy,
    output logic [15:0]               err_count
);
    localparam int ECHO_W = CMD_W - STAT_W;           // command without status bits
    localparam int HDR_W  = OPC_W + SEL_W + ADDR_W;   // echoed opcode/sel/addr
    localparam int ADDR_LSB = DATA_W;                 // offsets inside cmd_q
    localparam int SEL_LSB  = ADDR_LSB + ADDR_W;
    localparam logic [SEL_W:0] NUM_TGT_V = (SEL_W + 1)'(NUM_TGT);

    state_e              state;
    logic [ECHO_W-1:0]   cmd_q;
    logic [OPC_W-1:0]    opc;
    logic [SEL_W-1:0]    sel;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic                is_noop, is_wr, is_rd, sel_bad;
    logic [NUM_TGT-1:0]  sel_oh;
    logic [DATA_W-1:0]   rdata_sel;
    logic                ack_hit, tmo_expire;
    logic                unused_stat;

    // Incoming status bits carry no meaning for a command
    assign unused_stat = ^cmd_data[STAT_W-1:0];

    assign opc  = cmd_q[ECHO_W-1 -: OPC_W];
    assign sel  = cmd_q[SEL_LSB +: SEL_W];
    assign addr = cmd_q[ADDR_LSB +: ADDR_W];
    assign data = cmd_q[DATA_W-1:0];

    assign is_noop = (opc == OPC_W'(OPC_NOOP));
    assign is_wr   = (opc == OPC_W'(OPC_WRITE_REG));
    assign is_rd   = (opc == OPC_W'(OPC_READ_REG));
    assign sel_bad = ({1'b0, sel} >= NUM_TGT_V);

    // Decode select to one-hot and pick that target's read data
    always_comb begin
        sel_oh    = '0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            sel_oh[i] = (sel == SEL_W'(i));
            if (sel == SEL_W'(i)) rdata_sel = tgt_rdata[i*DATA_W +: DATA_W];
        end
    end

    // Acks from unselected targets never complete a transaction
    assign ack_hit = |(tgt_ack & sel_oh);

    assign cmd_rd  = (state == S_IDLE) && !cmd_empty && !reset;
    assign rb_wr   = (state == S_RESPOND) && !rb_full;
    assign tgt_req = (state == S_ISSUE) ? sel_oh : '0;
    assign busy    = (state != S_IDLE);

    cmd_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
        .sys_clk (sys_clk),
        .reset   (reset),
        .load    (state == S_DECODE),
        .count   ((state == S_ISSUE) && !ack_hit),
        .expire  (tmo_expire)
    );

    // Main FSM with registered transaction and readback outputs
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_q     <= '0;
            tgt_we    <= 1'b0;
            tgt_addr  <= '0;
            tgt_wdata <= '0;
            rb_data   <= '0;
            err_count <= '0;
        end else begin
            case (state)
                S_IDLE: if (!cmd_empty) state <= S_FETCH;
                S_FETCH: begin
                    cmd_q <= cmd_data[CMD_W-1:STAT_W];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_noop) begin
                        state <= S_IDLE;
                    end else if (!is_wr && !is_rd) begin
                        rb_data   <= {cmd_q, STAT_W'(ST_BAD_OPC)};
                        err_count <= sat_inc16(err_count);
                        state     <= S_RESPOND;
                    end else if (sel_bad) begin
                        rb_data   <= {cmd_q, STAT_W'(ST_BAD_SEL)};
                        err_count <= sat_inc16(err_count);
                        state     <= S_RESPOND;
                    end else begin
                        tgt_we    <= is_wr;
                        tgt_addr  <= addr;
                        tgt_wdata <= data;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ack_hit) begin
                        if (tgt_we) begin
                            state <= S_IDLE;
                        end else begin
                            rb_data <= {cmd_q[ECHO_W-1 -: HDR_W], rdata_sel, STAT_W'(ST_OK)};
                            state   <= S_RESPOND;
                        end
                    end else if (tmo_expire) begin
                        rb_data   <= {cmd_q, STAT_W'(ST_TIMEOUT)};
                        err_count <= sat_inc16(err_count);
                        state     <= S_RESPOND;
                    end
                end
                S_RESPOND: if (!rb_full) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: FIFO/target environment, vector table,
// hand-written corner sequences and randomized commands against a reference model.
module tb_cmd_dispatcher;
    import cmd_pkg::*;

    localparam int NT  = 3;
    localparam int TMO = 40;

    logic                sys_clk = 1'b0;
    logic                reset = 1'b1;
    logic [31:0]         cmd_data = '0;
    logic                cmd_empty = 1'b1;
    logic                cmd_rd;
    logic [31:0]         rb_data;
    logic                rb_full = 1'b0;
    logic                rb_wr;
    logic [NT-1:0]       tgt_req;
    logic                tgt_we;
    logic [4:0]          tgt_addr;
    logic [15:0]         tgt_wdata;
    logic [NT-1:0][15:0] rdv = '0;
    wire  [NT*16-1:0]    tgt_rdata = rdv;
    logic [NT-1:0]       tgt_ack = '0;
    logic                busy;
    logic [15:0]         err_count;

    cmd_dispatcher #(.NUM_TGT(NT), .TIMEOUT(TMO)) dut (
        .sys_clk(sys_clk), .reset(reset), .cmd_data(cmd_data), .cmd_empty(cmd_empty),
        .cmd_rd(cmd_rd), .rb_data(rb_data), .rb_full(rb_full), .rb_wr(rb_wr),
        .tgt_req(tgt_req), .tgt_we(tgt_we), .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata),
        .tgt_rdata(tgt_rdata), .tgt_ack(tgt_ack), .busy(busy), .err_count(err_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Environment state
    logic [31:0] fifo[$];
    logic [31:0] rb_got[$];
    bit          pend_pop, noise, rand_full, stab_bad;
    int          cyc, rd_cnt, rd_cyc, rd_first, req_cnt, req_first, rb_cyc, issue_cnt, ack_at;
    logic        rq_we;
    logic [4:0]  rq_addr;
    logic [15:0] rq_wdata;
    logic [NT-1:0] rq_mask;
    logic [15:0] err_m;
    int          n_chk, n_pass;

    typedef struct {
        bit          rb;
        logic [31:0] word;
        int          req;
        bit          we;
        bit          err;
    } exp_t;

    typedef struct {
        logic [31:0] cmd;
        int          ack;
        logic [15:0] rd;
        bit          rb;
        logic [31:0] word;
        int          req;
        bit          we;
        logic [15:0] err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Reference: what one command must produce, from the field/opcode/status rules
    function automatic exp_t model(input logic [31:0] c, input int ack, input logic [15:0] rd);
        exp_t e;
        int   opc, sel;
        opc = int'(c[31:27]);
        sel = int'(c[26:25]);
        e = '{0, 32'h0, 0, 0, 0};
        if (opc == OPC_NOOP) return e;
        if (opc != OPC_WRITE_REG && opc != OPC_READ_REG) begin
            e.rb = 1; e.err = 1; e.word = {c[31:4], 4'(ST_BAD_OPC)}; return e;
        end
        if (sel >= NT) begin
            e.rb = 1; e.err = 1; e.word = {c[31:4], 4'(ST_BAD_SEL)}; return e;
        end
        e.we = (opc == OPC_WRITE_REG);
        if (ack < 1 || ack > TMO) begin
            e.req = TMO; e.rb = 1; e.err = 1; e.word = {c[31:4], 4'(ST_TIMEOUT)};
        end else begin
            e.req = ack;
            if (!e.we) begin e.rb = 1; e.word = {c[31:20], rd, 4'(ST_OK)}; end
        end
        return e;
    endfunction

    // One cycle: sample outputs, clock edge, drive FIFO/target inputs, wait for negedge
    task automatic tick();
        #1;
        if (cmd_rd) begin
            pend_pop = 1;
            if (rd_cnt == 0) rd_first = cyc;
            rd_cnt++;
            rd_cyc = cyc;
        end
        if (rb_wr && !rb_full) begin rb_got.push_back(rb_data); rb_cyc = cyc; end
        if (tgt_req != 0) begin
            if (req_cnt == 0) begin
                req_first = cyc; rq_we = tgt_we; rq_addr = tgt_addr; rq_wdata = tgt_wdata; rq_mask = tgt_req;
            end else if (tgt_we !== rq_we || tgt_addr !== rq_addr || tgt_wdata !== rq_wdata || tgt_req !== rq_mask) begin
                stab_bad = 1;
            end
            req_cnt++;
        end
        @(posedge sys_clk);
        #1;
        cyc++;
        if (pend_pop) begin
            if (fifo.size() > 0) cmd_data = fifo.pop_front();
            pend_pop = 0;
        end
        cmd_empty = (fifo.size() == 0);
        if (rand_full) rb_full = ($urandom_range(0, 3) == 0);
        if (tgt_req == 0) issue_cnt = 0;
        else issue_cnt++;
        tgt_ack = '0;
        if (tgt_req != 0 && issue_cnt == ack_at) tgt_ack = tgt_req;
        if (noise) tgt_ack = tgt_ack | (NT'($urandom) & ~tgt_req);
        @(negedge sys_clk);
    endtask

    task automatic clr();
        rb_got.delete();
        rd_cnt = 0; req_cnt = 0; stab_bad = 0; rd_first = -1; rd_cyc = -1; rb_cyc = -1; req_first = -1;
    endtask

    task automatic push(input logic [31:0] c);
        fifo.push_back(c);
        cmd_empty = 1'b0;
    endtask

    task automatic run_until_idle(input int n_rd);
        bit ok;
        ok = 0;
        for (int b = 0; b < 4 * TMO + 200; b++) begin
            tick();
            if (rd_cnt >= n_rd && !busy && fifo.size() == 0) begin ok = 1; break; end
        end
        chk("idle_bound", 32'(ok), 32'd1);
    endtask

    // Run one command and compare everything observable against expectations
    task automatic do_cmd(input logic [31:0] c, input int ack, input logic [15:0] rd, input bit x_rb,
                          input logic [31:0] x_word, input int x_req, input bit x_we,
                          input logic [15:0] x_err, input bit lat);
        clr();
        ack_at = ack;
        for (int t = 0; t < NT; t++) rdv[t] = (t == int'(c[26:25])) ? rd : 16'($urandom);
        push(c);
        run_until_idle(1);
        chk("rb_count", 32'(rb_got.size()), 32'(x_rb));
        if (x_rb && rb_got.size() > 0) chk("rb_word", rb_got[0], x_word);
        chk("req_cycles", 32'(req_cnt), 32'(x_req));
        chk("err_count", 32'(err_count), 32'(x_err));
        if (x_req > 0) begin
            chk("tgt_req_sel", 32'(rq_mask), 32'(1) << c[26:25]);
            chk("tgt_we", 32'(rq_we), 32'(x_we));
            chk("tgt_addr", 32'(rq_addr), 32'(c[24:20]));
            chk("tgt_wdata", 32'(rq_wdata), 32'(c[19:4]));
            chk("req_stable", 32'(stab_bad), 32'd0);
        end
        if (lat) begin
            if (x_req > 0) chk("req_latency", 32'(req_first - rd_cyc), 32'd3);
            if (x_rb) chk("rb_latency", 32'(rb_cyc - rd_cyc), 32'(x_req > 0 ? 3 + x_req : 3));
        end
    endtask

    initial begin
        logic [31:0] c, xw;
        int          a;
        bit          hold_bad;
        exp_t        e;

        tbl[0] = '{32'h0C3BEEF0, 2, 16'h0000, 1'b0, 32'h0,        2,   1'b1, 16'd0};
        tbl[1] = '{32'h14300000, 1, 16'hBEEF, 1'b1, 32'h143BEEF0, 1,   1'b0, 16'd0};
        tbl[2] = '{32'h10100000, 0, 16'h1234, 1'b1, 32'h10100001, TMO, 1'b0, 16'd1};
        tbl[3] = '{32'h0E012340, 1, 16'h0000, 1'b1, 32'h0E012342, 0,   1'b0, 16'd2};
        tbl[4] = '{32'h18000000, 1, 16'h0000, 1'b1, 32'h18000003, 0,   1'b0, 16'd3};
        tbl[5] = '{32'h00000000, 1, 16'h0000, 1'b0, 32'h0,        0,   1'b0, 16'd3};

        // Reset state
        clr();
        repeat (2) @(posedge sys_clk);
        #2;
        chk("rst_cmd_rd", 32'(cmd_rd), 32'd0);
        chk("rst_rb_wr", 32'(rb_wr), 32'd0);
        chk("rst_tgt_req", 32'(tgt_req), 32'd0);
        chk("rst_tgt_we", 32'(tgt_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tgt_addr", 32'(tgt_addr), 32'd0);
        chk("rst_tgt_wdata", 32'(tgt_wdata), 32'd0);
        chk("rst_rb_data", rb_data, 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        @(negedge sys_clk);
        reset = 1'b0;

        // Table vectors: write, same-cycle read, timeout, bad sel, bad opcode, NOOP
        for (int i = 0; i < 6; i++)
            do_cmd(tbl[i].cmd, tbl[i].ack, tbl[i].rd, tbl[i].rb, tbl[i].word, tbl[i].req,
                   tbl[i].we, tbl[i].err, 1'b1);
        err_m = 16'd3;

        // Back-to-back zero-wait writes: second fetch in the very next IDLE cycle
        clr();
        ack_at = 1;
        push({5'd1, 2'd0, 5'd1, 16'h1111, 4'h0});
        push({5'd1, 2'd1, 5'd2, 16'h2222, 4'h0});
        run_until_idle(2);
        chk("b2b_rd_count", 32'(rd_cnt), 32'd2);
        chk("b2b_rd_gap", 32'(rd_cyc - rd_first), 32'd4);
        chk("b2b_req_cycles", 32'(req_cnt), 32'd2);
        chk("b2b_rb_count", 32'(rb_got.size()), 32'd0);

        // Backpressure: readback held while FIFO full, no new fetch
        clr();
        ack_at = 1;
        c = {5'd2, 2'd0, 5'd9, 16'h1234, 4'h0};
        rdv[0] = 16'hC0DE; rdv[1] = 16'h1111; rdv[2] = 16'h2222;
        xw = {5'd2, 2'd0, 5'd9, 16'hC0DE, 4'h0};
        rb_full = 1'b1;
        push(c);
        push(32'h0);
        repeat (16) tick();
        chk("bp_rb_data", rb_data, xw);
        chk("bp_busy", 32'(busy), 32'd1);
        hold_bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rb_data !== xw || !busy) hold_bad = 1;
        end
        chk("bp_hold", 32'(hold_bad), 32'd0);
        chk("bp_no_write", 32'(rb_got.size()), 32'd0);
        chk("bp_no_fetch", 32'(rd_cnt), 32'd1);
        rb_full = 1'b0;
        run_until_idle(2);
        chk("bp_one_write", 32'(rb_got.size()), 32'd1);
        if (rb_got.size() > 0) chk("bp_word", rb_got[0], xw);
        chk("bp_rd_count", 32'(rd_cnt), 32'd2);
        chk("bp_err_count", 32'(err_count), 32'(err_m));

        // Reset in the middle of an ISSUE on target 1
        clr();
        ack_at = 0;
        push({5'd2, 2'd1, 5'd4, 16'h0000, 4'h0});
        for (int b = 0; b < 20 && !tgt_req[1]; b++) tick();
        chk("mid_reach_issue", 32'(tgt_req), 32'b010);
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("mid_tgt_req", 32'(tgt_req), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_cmd_rd", 32'(cmd_rd), 32'd0);
        chk("mid_rb_wr", 32'(rb_wr), 32'd0);
        chk("mid_rb_data", rb_data, 32'd0);
        chk("mid_err_count", 32'(err_count), 32'd0);
        err_m = 16'd0;
        @(negedge sys_clk);
        reset = 1'b0;
        repeat (3) tick();
        chk("mid_no_readback", 32'(rb_got.size()), 32'd0);
        do_cmd({5'd1, 2'd1, 5'd7, 16'hA5A5, 4'h0}, 2, 16'h0, 1'b0, 32'h0, 2, 1'b1, err_m, 1'b1);

        // Randomized commands with stray acks and random readback backpressure
        noise = 1; rand_full = 1;
        for (int k = 0; k < 60; k++) begin
            logic [15:0] rd;
            c = $urandom;
            case ($urandom_range(0, 7))
                0: c[31:27] = 5'(OPC_NOOP);
                1, 2: c[31:27] = 5'(OPC_WRITE_REG);
                3, 4: c[31:27] = 5'(OPC_READ_REG);
                5: c[31:27] = 5'(OPC_WRITE_RAM);
                6: c[31:27] = 5'(OPC_READ_RAM);
                default: c[31:27] = 5'($urandom);
            endcase
            if ($urandom_range(0, 3) != 0) c[26:25] = 2'($urandom_range(SEL_INT, SEL_ADC));
            a = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            rd = 16'($urandom);
            e = model(c, a, rd);
            if (e.err) err_m = sat_inc16(err_m);
            do_cmd(c, a, rd, e.rb, e.word, e.req, e.we, err_m, 1'b0);
        end
        noise = 0; rand_full = 0; rb_full = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
